// File: rtl/unload_pkg.sv
// rtl/unload_pkg.sv - widths, FSM states and header check shared by unload_reader
// Optional build macro: UNLOAD_PARITY_EN (adds odd-parity header rejection)
package unload_pkg;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 16;
  localparam int FIFO_DEPTH  = 2;
  localparam int HDR_COUNT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_REQ,
    ST_HDR_WAIT,
    ST_STREAM,
    ST_DRAIN
  } unload_state_t;

  // Header is malformed when any reserved bit above the count is set.
  function automatic logic hdr_malformed(input logic [DATA_W-1:0] hdr);
    logic bad;
    bad = |hdr[DATA_W-1:HDR_COUNT_W];
`ifdef UNLOAD_PARITY_EN
    bad = bad | (^hdr);
`endif
    return bad;
  endfunction

endpackage

// File: rtl/unload_skid_fifo.sv
// rtl/unload_skid_fifo.sv - 2-entry FIFO holding SRAM return data ahead of the stream port
module unload_skid_fifo
  import unload_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/unload_reader.sv
// rtl/unload_reader.sv - reads a counted result region from SRAM and streams it out
// Optional build macro: UNLOAD_PARITY_EN (out_parity port and header parity check)
module unload_reader
  import unload_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic              unload_run,
  output logic              unload_busy,
  input  logic [ADDR_W-1:0] unload_base_addr,
  output logic [ADDR_W-1:0] unload_sram_read_address,
  input  logic [DATA_W-1:0] sram_unload_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
`ifdef UNLOAD_PARITY_EN
  output logic              out_parity,
`endif
  output logic              out_error
);

  unload_state_t          r_state;
  unload_state_t          w_next;
  logic [ADDR_W-1:0]      r_addr;
  logic [HDR_COUNT_W-1:0] r_count;
  logic [HDR_COUNT_W-1:0] r_issued;
  logic [HDR_COUNT_W-1:0] r_popped;
  logic                   r_inflight;
  logic                   r_error;

  logic                   w_accept;
  logic                   w_issue;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_credit;
  logic                   w_hdr_bad;
  logic [HDR_COUNT_W-1:0] w_hdr_count;
  logic [1:0]             w_occ;
  logic [2:0]             w_load;

  assign w_hdr_bad   = hdr_malformed(sram_unload_read_data);
  assign w_hdr_count = sram_unload_read_data[HDR_COUNT_W-1:0];
  assign w_pop       = out_valid && out_ready;

  // A read may be issued when the FIFO can absorb it after this cycle's pop
  // and the return already in flight; this sustains one word per cycle.
  assign w_occ    = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
  assign w_load   = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_credit = (w_load < 3'd2);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (unload_run) begin
          w_accept = 1'b1;
          w_next   = ST_HDR_REQ;
        end
      end
      ST_HDR_REQ: w_next = ST_HDR_WAIT;
      ST_HDR_WAIT: begin
        // The base+1 read presented this cycle is kept only for a good header.
        if (w_hdr_bad || (w_hdr_count == '0)) begin
          w_next = ST_IDLE;
        end else begin
          w_issue = 1'b1;
          w_next  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if ((r_issued != r_count) && w_credit) w_issue = 1'b1;
        if ((r_issued + {{(HDR_COUNT_W-1){1'b0}}, w_issue}) == r_count) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pop && out_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_error    <= (r_state == ST_HDR_WAIT) && w_hdr_bad;
      if (w_accept) begin
        r_addr   <= unload_base_addr;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if ((r_state == ST_HDR_REQ) || w_issue) r_addr <= r_addr + ADDR_W'(1);
        if (w_issue) r_issued <= r_issued + HDR_COUNT_W'(1);
        if (w_pop)   r_popped <= r_popped + HDR_COUNT_W'(1);
      end
      if (r_state == ST_HDR_WAIT) r_count <= w_hdr_count;
    end
  end

  unload_skid_fifo u_fifo (
    .clk         (clk),
    .rst_n       (reset_b),
    .i_push      (r_inflight),
    .i_push_data (sram_unload_read_data),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (out_data)
  );

  assign unload_busy              = (r_state != ST_IDLE);
  assign unload_sram_read_address = (r_state == ST_IDLE) ? '0 : r_addr;
  assign out_valid                = !w_empty;
  assign out_last                 = out_valid && ((r_popped + HDR_COUNT_W'(1)) == r_count);
  assign out_error                = r_error;
`ifdef UNLOAD_PARITY_EN
  assign out_parity               = ^out_data;
`endif

endmodule

// File: tb/tb_unload_reader.sv
// tb/tb_unload_reader.sv - self-checking bench for unload_reader against an SRAM and stream model
// Optional build macro: UNLOAD_PARITY_EN (also checks out_parity and header parity rejection)
module tb_unload_reader;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        unload_run = 1'b0;
  logic        unload_busy;
  logic [11:0] unload_base_addr = '0;
  logic [11:0] unload_sram_read_address;
  logic [15:0] sram_unload_read_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_error;
`ifdef UNLOAD_PARITY_EN
  logic        out_parity;
  int          par_viol;
`endif

  unload_reader dut (
    .clk                      (clk),
    .reset_b                  (reset_b),
    .unload_run               (unload_run),
    .unload_busy              (unload_busy),
    .unload_base_addr         (unload_base_addr),
    .unload_sram_read_address (unload_sram_read_address),
    .sram_unload_read_data    (sram_unload_read_data),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .out_data                 (out_data),
    .out_last                 (out_last),
`ifdef UNLOAD_PARITY_EN
    .out_parity               (out_parity),
`endif
    .out_error                (out_error)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4096];
  always @(posedge clk) sram_unload_read_data <= mem[unload_sram_read_address];

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  bit          last_q[$];
  int          hs_q[$];
  logic [11:0] addr_at [64];
  int          first_valid, valid_cnt, err_cnt, stall_viol, done_k;
  logic [45:0] snap;

  function automatic logic ready_of(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Programs the SRAM, builds the expected stream, runs one transfer and records what came out.
  task automatic run_transfer(input logic [11:0] base, input logic [15:0] hdr, input int mode,
                              input bit fixed, input int rerun_k, input int reset_k);
    int          n;
    bit          bad;
    bit          stalled_prev;
    logic [15:0] prev_data;
    logic [15:0] w;
    logic [11:0] a;
    n   = int'(hdr[11:0]);
    bad = (hdr[15:12] != 4'd0);
`ifdef UNLOAD_PARITY_EN
    bad = bad || (^hdr);
    par_viol = 0;
`endif
    exp_q.delete(); got_q.delete(); last_q.delete(); hs_q.delete();
    first_valid = -1; valid_cnt = 0; err_cnt = 0; stall_viol = 0; done_k = -1;
    stalled_prev = 1'b0; prev_data = '0;
    for (int i = 0; i < 64; i++) addr_at[i] = '0;
    mem[base] = hdr;
    for (int i = 1; i <= n; i++) begin
      w = fixed ? 16'(16'h00A0 + i) : 16'($urandom);
      a = base + 12'(i);
      mem[a] = w;
      if (!bad) exp_q.push_back(w);
    end
    @(posedge clk); #1;
    unload_base_addr = base;
    unload_run = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 300; k++) begin
      out_ready = ready_of(mode, k);
      if (k == rerun_k) begin
        unload_run = 1'b1;
        unload_base_addr = base ^ 12'h555;
      end else begin
        unload_run = 1'b0;
      end
      @(negedge clk);
      if (k < 64) addr_at[k] = unload_sram_read_address;
      if (out_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = k;
      end
      if (stalled_prev && (!out_valid || out_data !== prev_data)) stall_viol++;
      stalled_prev = out_valid && !out_ready;
      prev_data = out_data;
`ifdef UNLOAD_PARITY_EN
      if (out_valid && out_parity !== ^out_data) par_viol++;
`endif
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        hs_q.push_back(k);
      end
      if (out_error) err_cnt++;
      if (k == reset_k) begin
        #2 reset_b = 1'b0;
        #1 snap = {unload_busy, out_valid, out_last, out_error, out_data, unload_sram_read_address};
        done_k = k;
        break;
      end
      if (!unload_busy) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    unload_run = 1'b0;
    if (reset_k == 0 && done_k > 0) begin
      @(posedge clk);
      @(negedge clk);
      if (out_error) err_cnt++;
      if (out_valid) valid_cnt++;
    end
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (unload_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", unload_busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_checks++; if (out_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", out_error); end
    n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", out_data); end
    n_checks++; if (unload_sram_read_address !== 12'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 000", unload_sram_read_address); end
    reset_b = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    run_transfer(12'h100, 16'h0003, 0, 1'b1, 0, 0);
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_checks++; if (got_q[i] !== 16'(16'h00A1 + i)) begin n_fail++; $display("FAIL basic_word%0d: got %h want %h", i, got_q[i], 16'(16'h00A1 + i)); end
      n_checks++; if (hs_q[i] != 4 + i) begin n_fail++; $display("FAIL basic_cycle%0d: got %0d want %0d", i, hs_q[i], 4 + i); end
      n_checks++; if (last_q[i] !== (i == 2)) begin n_fail++; $display("FAIL basic_last%0d: got %b want %b", i, last_q[i], i == 2); end
    end
    n_checks++; if (first_valid != 4) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d want 4", first_valid); end
    n_checks++; if (addr_at[1] !== 12'h100) begin n_fail++; $display("FAIL basic_hdr_addr: got %h want 100", addr_at[1]); end
    n_checks++; if (addr_at[2] !== 12'h101) begin n_fail++; $display("FAIL basic_data_addr: got %h want 101", addr_at[2]); end
    n_checks++; if (done_k != 7) begin n_fail++; $display("FAIL basic_busy_fall: got cycle %0d want 7", done_k); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL basic_error: got %0d pulses want 0", err_cnt); end
`ifdef UNLOAD_PARITY_EN
    n_checks++; if (par_viol != 0) begin n_fail++; $display("FAIL basic_parity: got %0d bad cycles want 0", par_viol); end
`endif
  endtask

  task automatic test_empty_header();
    run_transfer(12'h200, 16'h0000, 0, 1'b0, 0, 0);
    n_checks++; if (valid_cnt != 0) begin n_fail++; $display("FAIL empty_valid: got %0d valid cycles want 0", valid_cnt); end
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL empty_error: got %0d pulses want 0", err_cnt); end
    n_checks++; if (done_k != 3) begin n_fail++; $display("FAIL empty_busy_fall: got cycle %0d want 3", done_k); end
  endtask

  task automatic test_bad_header();
    run_transfer(12'h240, 16'h1005, 0, 1'b0, 0, 0);
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL bad_hdr_error: got %0d pulses want 1", err_cnt); end
    n_checks++; if (valid_cnt != 0) begin n_fail++; $display("FAIL bad_hdr_valid: got %0d valid cycles want 0", valid_cnt); end
    n_checks++; if (done_k != 3) begin n_fail++; $display("FAIL bad_hdr_idle: got cycle %0d want 3", done_k); end
  endtask

  task automatic test_stall();
    run_transfer(12'h2A0, 16'h0005, 1, 1'b0, 3, 0);
    n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      n_checks++; if (last_q[i] !== (i == 4)) begin n_fail++; $display("FAIL stall_last%0d: got %b want %b", i, last_q[i], i == 4); end
    end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_viol); end
    n_checks++; if (hs_q.size() == 0 || done_k != hs_q[hs_q.size()-1] + 1) begin n_fail++; $display("FAIL stall_busy_fall: got cycle %0d want one after last handshake", done_k); end
  endtask

  task automatic test_wrap();
    run_transfer(12'hFFE, 16'h0003, 0, 1'b0, 0, 0);
    n_checks++; if (addr_at[2] !== 12'hFFF) begin n_fail++; $display("FAIL wrap_addr0: got %h want fff", addr_at[2]); end
    n_checks++; if (addr_at[3] !== 12'h000) begin n_fail++; $display("FAIL wrap_addr1: got %h want 000", addr_at[3]); end
    n_checks++; if (addr_at[4] !== 12'h001) begin n_fail++; $display("FAIL wrap_addr2: got %h want 001", addr_at[4]); end
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] hdr;
    int          n;
    bit          bad;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 12);
      hdr = {4'd0, 12'(n)};
      if ($urandom_range(0, 3) == 0) hdr[15:12] = 4'($urandom_range(1, 15));
      bad = (hdr[15:12] != 4'd0);
`ifdef UNLOAD_PARITY_EN
      bad = bad || (^hdr);
`endif
      run_transfer(12'($urandom), hdr, 2, 1'b0, 0, 0);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d: got %h want %h", it, i, got_q[i], exp_q[i]); end
        n_checks++; if (last_q[i] !== (i == exp_q.size() - 1)) begin n_fail++; $display("FAIL rand%0d_last%0d: got %b", it, i, last_q[i]); end
      end
      n_checks++; if (err_cnt != int'(bad)) begin n_fail++; $display("FAIL rand%0d_error: got %0d pulses want %0d", it, err_cnt, int'(bad)); end
      n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d unstable cycles want 0", it, stall_viol); end
      n_checks++; if (done_k <= 0) begin n_fail++; $display("FAIL rand%0d_timeout: got done cycle %0d want >0", it, done_k); end
    end
  endtask

  task automatic test_reset_mid();
    int idle_viol;
    run_transfer(12'h300, 16'h0006, 0, 1'b0, 0, 5);
    n_checks++; if (snap !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", snap); end
    n_checks++; if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL midreset_word0: got %0d words want first %h", got_q.size(), exp_q[0]); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    idle_viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (unload_busy || out_valid || out_error) idle_viol++;
    end
    n_checks++; if (idle_viol != 0) begin n_fail++; $display("FAIL midreset_no_resume: got %0d active cycles want 0", idle_viol); end
    run_transfer(12'h340, 16'h0004, 0, 1'b0, 0, 0);
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL after_reset_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL after_reset_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (done_k != 8) begin n_fail++; $display("FAIL after_reset_busy_fall: got cycle %0d want 8", done_k); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_header();
    test_bad_header();
    test_stall();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unload_reader.md
UNLOAD_READER -- requirements
Module: unload_reader

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 reset_b  input  1  asynchronous, active-low reset.
REQ-003 unload_run  input  1  start pulse; sampled only when idle.
REQ-004 unload_busy  output  1  high from the cycle after run is accepted until return to IDLE.
REQ-005 unload_base_addr  input  12  SRAM address of the result header; captured on run acceptance.
REQ-006 unload_sram_read_address  output  12  SRAM read address; synchronous SRAM, data valid on the next cycle.
REQ-007 sram_unload_read_data  input  16  SRAM read data for the address presented on the previous cycle.
REQ-008 out_valid  output  1  stream word valid.
REQ-009 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-010 out_data  output  16  result word.
REQ-011 out_last  output  1  high with the final word of a transfer.
REQ-012 out_error  output  1  one-cycle pulse when the header is malformed.

Function
REQ-013 Purpose: read the result region written by the convolution engine back out of SRAM and stream it over the valid/ready interface.
REQ-014 SRAM layout: word at base is the header (bits [11:0] count N, bits [15:12] must be 0); words base+1 .. base+N are results.
REQ-015 FSM states: IDLE, HDR_REQ, HDR_WAIT, STREAM, DRAIN.
REQ-016 IDLE: unload_run=1 captures base and goes to HDR_REQ; no other input has effect.
REQ-017 HDR_REQ: drive address=base, then go to HDR_WAIT.
REQ-018 HDR_WAIT: latch the header from read data.
REQ-019 HDR_WAIT, nonzero [15:12]: pulse out_error and go to IDLE; no word is streamed.
REQ-020 HDR_WAIT, N=0: go to IDLE with no out_valid.
REQ-021 HDR_WAIT, otherwise: go to STREAM.
REQ-022 STREAM: issue reads at base+1 onward; issue a read only if FIFO occupancy plus in-flight reads is less than 2.
REQ-023 STREAM: after N reads are issued, go to DRAIN.
REQ-024 DRAIN: go to IDLE in the cycle the last word handshakes.
REQ-025 Returned data enters a 2-entry FIFO; out_valid = FIFO not empty; out_data = FIFO head.
REQ-026 Sustained throughput is 1 word per cycle while out_ready=1.
REQ-027 Latency: run sampled at edge 0 gives header address in cycle 1, first data address in cycle 2, out_valid first high in cycle 4.
REQ-028 out_data is stable and out_valid never deasserts until the handshake completes.
REQ-029 Addresses are 12-bit and wrap modulo 4096; wrap is not an error.
REQ-030 out_last is high only with word N; unload_busy falls in the cycle after that handshake.
REQ-031 unload_run while busy is ignored.
REQ-032 A FIFO push and pop in the same cycle keeps occupancy unchanged.

Reset
REQ-033 reset_b low, at any time including mid-transfer, forces: state IDLE, FIFO empty, in-flight count 0, unload_busy=0, out_valid=0, out_last=0, out_error=0, out_data=0, unload_sram_read_address=0.
REQ-034 No partial transfer resumes after reset is released.

Configuration
REQ-035 UNLOAD_PARITY_EN defined: add output out_parity (1 bit) = even parity of out_data, valid with out_valid; a header with odd parity over its 16 bits also causes out_error and return to IDLE.
REQ-036 UNLOAD_PARITY_EN undefined: no out_parity port and no header parity check.

Structure
REQ-037 Package unload_pkg holds ADDR_W=12, DATA_W=16, FIFO_DEPTH=2, HDR_COUNT_W=12 and the FSM state enum.
REQ-038 Sub-module unload_skid_fifo holds the 2-entry FIFO (push, pop, full, empty, head).

Verification
REQ-039 base=0x100, header 0x0003, data A1,A2,A3, out_ready=1 -> A1,A2,A3 on consecutive cycles from cycle 4; out_last with A3.
REQ-040 Header 0x0000 -> no out_valid; unload_busy drops after header read.
REQ-041 Header 0x1005 -> single out_error pulse; no out_valid; returns to IDLE.
REQ-042 N=5 with out_ready toggling 1,0,0,1,... -> all 5 words in order, none lost or duplicated, out_data stable while stalled.
REQ-043 base=0xFFE, N=3 -> reads at 0xFFF, 0x000, 0x001.
REQ-044 reset_b low during word 2 of 6 -> all outputs 0 asynchronously; a new run then completes normally.
